counter_gen: RTL and testbench

- Parametrised successor to the lab's basic 8-bit preloadable counter.
- Adds configurable width, up/down direction, a programmable terminal value, wrap or saturate mode, a terminal-count pulse and a sticky overflow flag.
- Used stand-alone in labs and as a timebase/event counter in later designs.
- Single clock domain; all outputs registered.

---
 rtl/counter_pkg.sv | 12 +
 rtl/counter_step.sv | 26 ++
 rtl/counter_gen.sv | 46 ++++
 tb/tb_counter_gen.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// counter_pkg: shared direction/mode constants and preload clamping for counter_gen
package counter_pkg;
  localparam int MAX_W = 64;
  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT = 1'b1;
  // Operands arrive zero-extended to MAX_W; caller truncates back to its width
  function automatic logic [MAX_W-1:0] load_val(input logic [MAX_W-1:0] pl, input logic [MAX_W-1:0] mx);
    return pl > mx ? mx : pl;
  endfunction
endpackage

// File: rtl/counter_step.sv
// counter_step: combinational next count and boundary-event flag
module counter_step
  import counter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] cur,
  input  logic [WIDTH-1:0] max_val,
  input  logic             up_dn,
  input  logic             sat_mode,
  output logic [WIDTH-1:0] nxt,
  output logic             bnd
);
  logic up, sat, up_bnd, dn_bnd, dn_over;
  logic [WIDTH-1:0] up_nxt, dn_nxt;
  assign up = up_dn == DIR_UP;
  assign sat = sat_mode == MODE_SAT;
  assign up_bnd = cur >= max_val;
  assign dn_bnd = cur == '0;
  // count above a lowered max_val snaps down to it without a boundary event
  assign dn_over = cur > max_val;
  assign up_nxt = up_bnd ? (sat ? max_val : '0) : cur + WIDTH'(1);
  assign dn_nxt = dn_over ? max_val : dn_bnd ? (sat ? '0 : max_val) : cur - WIDTH'(1);
  assign nxt = up ? up_nxt : dn_nxt;
  assign bnd = up ? up_bnd : dn_bnd;
endmodule

// File: rtl/counter_gen.sv
// counter_gen: parametrised up/down counter with terminal value, wrap/saturate, tc pulse and sticky ovf
module counter_gen
  import counter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int PL_WIDTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                preload,
  input  logic [PL_WIDTH-1:0] pl_data,
  input  logic                up_dn,
  input  logic                sat_mode,
  input  logic [WIDTH-1:0]    max_val,
  input  logic                clr_ovf,
  output logic [WIDTH-1:0]    cout,
  output logic                tc,
  output logic                ovf
);
  logic [WIDTH-1:0] nxt, ld;
  logic bnd, step, evt;
  counter_step #(.WIDTH(WIDTH)) u_step (
    .cur(cout),
    .max_val(max_val),
    .up_dn(up_dn),
    .sat_mode(sat_mode),
    .nxt(nxt),
    .bnd(bnd)
  );
  assign ld = WIDTH'(load_val(MAX_W'(pl_data), MAX_W'(max_val)));
  assign step = enable & ~preload;
  assign evt = step & bnd;
  // a boundary event outranks a coincident clr_ovf
  always_ff @(posedge clk) begin
    if (reset) begin
      cout <= '0;
      tc <= 1'b0;
      ovf <= 1'b0;
    end else begin
      cout <= preload ? ld : step ? nxt : cout;
      tc <= evt;
      ovf <= evt | (ovf & ~clr_ovf);
    end
  end
endmodule

// File: tb/tb_counter_gen.sv
// tb_counter_gen: directed self-checking bench for counter_gen (WIDTH=8, PL_WIDTH=4)
module tb_counter_gen;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic preload = 1'b0;
  logic [3:0] pl_data = 4'd0;
  logic up_dn = 1'b1;
  logic sat_mode = 1'b0;
  logic [7:0] max_val = 8'd255;
  logic clr_ovf = 1'b0;
  logic [7:0] cout;
  logic tc, ovf;
  int checks = 0;
  int errors = 0;

  counter_gen #(.WIDTH(8), .PL_WIDTH(4)) dut (
    .clk(clk), .reset(reset), .enable(enable), .preload(preload), .pl_data(pl_data),
    .up_dn(up_dn), .sat_mode(sat_mode), .max_val(max_val), .clr_ovf(clr_ovf),
    .cout(cout), .tc(tc), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_preload(input logic [3:0] v);
    preload = 1'b1;
    pl_data = v;
    tick(1);
    preload = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    enable = 1'b1;
    tick(3);
    checks++; if (cout !== 8'd0) begin errors++; $display("FAIL reset_cout got=%0d exp=0", cout); end
    checks++; if (tc !== 1'b0) begin errors++; $display("FAIL reset_tc got=%b exp=0", tc); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
    reset = 1'b0;
  endtask

  task automatic test_basic;
    max_val = 8'd255; up_dn = 1'b1; sat_mode = 1'b0; enable = 1'b1;
    tick(26);
    checks++; if (cout !== 8'd26) begin errors++; $display("FAIL basic_26 got=%0d exp=26", cout); end
    checks++; if (tc !== 1'b0 || ovf !== 1'b0) begin errors++; $display("FAIL basic_flags tc=%b ovf=%b exp=0/0", tc, ovf); end
    do_preload(4'd5);
    checks++; if (cout !== 8'd5) begin errors++; $display("FAIL basic_pl5 got=%0d exp=5", cout); end
    tick(10);
    checks++; if (cout !== 8'd15) begin errors++; $display("FAIL basic_15 got=%0d exp=15", cout); end
    do_preload(4'd2);
    checks++; if (cout !== 8'd2) begin errors++; $display("FAIL basic_pl2 got=%0d exp=2", cout); end
  endtask

  task automatic test_hold;
    tick(10);
    checks++; if (cout !== 8'd12) begin errors++; $display("FAIL hold_pre got=%0d exp=12", cout); end
    enable = 1'b0;
    tick(10);
    checks++; if (cout !== 8'd12 || tc !== 1'b0) begin errors++; $display("FAIL hold_keep cout=%0d tc=%b exp=12/0", cout, tc); end
    enable = 1'b1;
    tick(3);
    checks++; if (cout !== 8'd15) begin errors++; $display("FAIL hold_resume got=%0d exp=15", cout); end
  endtask

  task automatic test_up_wrap;
    max_val = 8'd9;
    do_preload(4'd0);
    checks++; if (cout !== 8'd0) begin errors++; $display("FAIL wrap_start got=%0d exp=0", cout); end
    tick(9);
    checks++; if (cout !== 8'd9 || tc !== 1'b0) begin errors++; $display("FAIL wrap_at9 cout=%0d tc=%b exp=9/0", cout, tc); end
    tick(1);
    checks++; if (cout !== 8'd0 || tc !== 1'b1 || ovf !== 1'b1) begin errors++; $display("FAIL wrap_evt cout=%0d tc=%b ovf=%b exp=0/1/1", cout, tc, ovf); end
    tick(1);
    checks++; if (cout !== 8'd1 || tc !== 1'b0 || ovf !== 1'b1) begin errors++; $display("FAIL wrap_after cout=%0d tc=%b ovf=%b exp=1/0/1", cout, tc, ovf); end
    clr_ovf = 1'b1;
    tick(1);
    clr_ovf = 1'b0;
    checks++; if (ovf !== 1'b0 || cout !== 8'd2) begin errors++; $display("FAIL wrap_clr ovf=%b cout=%0d exp=0/2", ovf, cout); end
  endtask

  task automatic test_down_sat;
    logic [7:0] exp_c [5] = '{8'd1, 8'd0, 8'd0, 8'd0, 8'd0};
    logic exp_t [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic exp_o [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    up_dn = 1'b0; sat_mode = 1'b1;
    do_preload(4'd2);
    checks++; if (cout !== 8'd2 || tc !== 1'b0) begin errors++; $display("FAIL dsat_pl cout=%0d tc=%b exp=2/0", cout, tc); end
    for (int i = 0; i < 5; i++) begin
      tick(1);
      checks++;
      if (cout !== exp_c[i] || tc !== exp_t[i] || ovf !== exp_o[i]) begin
        errors++;
        $display("FAIL dsat_step%0d cout=%0d tc=%b ovf=%b exp=%0d/%b/%b", i, cout, tc, ovf, exp_c[i], exp_t[i], exp_o[i]);
      end
    end
    enable = 1'b0;
    tick(1);
    checks++; if (tc !== 1'b0 || cout !== 8'd0) begin errors++; $display("FAIL dsat_dis tc=%b cout=%0d exp=0/0", tc, cout); end
    enable = 1'b1;
  endtask

  task automatic test_sat_up;
    up_dn = 1'b1; sat_mode = 1'b1; max_val = 8'd9;
    do_preload(4'd9);
    tick(2);
    checks++; if (cout !== 8'd9 || tc !== 1'b1) begin errors++; $display("FAIL usat_hold cout=%0d tc=%b exp=9/1", cout, tc); end
  endtask

  task automatic test_clamp;
    max_val = 8'd3; clr_ovf = 1'b1;
    do_preload(4'd9);
    clr_ovf = 1'b0;
    checks++; if (cout !== 8'd3 || tc !== 1'b0 || ovf !== 1'b0) begin errors++; $display("FAIL clamp_pl cout=%0d tc=%b ovf=%b exp=3/0/0", cout, tc, ovf); end
    max_val = 8'd1; up_dn = 1'b0; sat_mode = 1'b0;
    tick(1);
    checks++; if (cout !== 8'd1 || tc !== 1'b0 || ovf !== 1'b0) begin errors++; $display("FAIL clamp_lower cout=%0d tc=%b ovf=%b exp=1/0/0", cout, tc, ovf); end
  endtask

  task automatic test_max_zero;
    max_val = 8'd0; up_dn = 1'b1;
    tick(1);
    checks++; if (cout !== 8'd0 || tc !== 1'b1) begin errors++; $display("FAIL mz_first cout=%0d tc=%b exp=0/1", cout, tc); end
    tick(1);
    checks++; if (cout !== 8'd0 || tc !== 1'b1) begin errors++; $display("FAIL mz_second cout=%0d tc=%b exp=0/1", cout, tc); end
  endtask

  task automatic test_full_wrap;
    max_val = 8'd255; up_dn = 1'b0;
    tick(1);
    checks++; if (cout !== 8'd255 || tc !== 1'b1) begin errors++; $display("FAIL full_dn cout=%0d tc=%b exp=255/1", cout, tc); end
    up_dn = 1'b1;
    tick(1);
    checks++; if (cout !== 8'd0 || tc !== 1'b1) begin errors++; $display("FAIL full_up cout=%0d tc=%b exp=0/1", cout, tc); end
  endtask

  task automatic test_simultaneous;
    enable = 1'b0; clr_ovf = 1'b1;
    tick(1);
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL sim_clr ovf=%b exp=0", ovf); end
    max_val = 8'd9; up_dn = 1'b1; sat_mode = 1'b0; clr_ovf = 1'b0;
    do_preload(4'd9);
    enable = 1'b1; clr_ovf = 1'b1;
    tick(1);
    clr_ovf = 1'b0;
    checks++; if (cout !== 8'd0 || tc !== 1'b1 || ovf !== 1'b1) begin errors++; $display("FAIL sim_setwins cout=%0d tc=%b ovf=%b exp=0/1/1", cout, tc, ovf); end
    do_preload(4'd6);
    tick(1);
    checks++; if (cout !== 8'd7) begin errors++; $display("FAIL sim_mid got=%0d exp=7", cout); end
    reset = 1'b1; preload = 1'b1; pl_data = 4'd4;
    tick(1);
    reset = 1'b0; preload = 1'b0;
    checks++; if (cout !== 8'd0 || tc !== 1'b0 || ovf !== 1'b0) begin errors++; $display("FAIL sim_reset cout=%0d tc=%b ovf=%b exp=0/0/0", cout, tc, ovf); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_up_wrap();
    test_down_sat();
    test_sat_up();
    test_clamp();
    test_max_zero();
    test_full_wrap();
    test_simultaneous();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
